// File: rtl/branch_checkpoint_stack.sv
// Circular buffer of free-list snapshots, one per in-flight branch.
// Mispredicts restore the branch's snapshot and squash all younger entries;
// retiring T_old registers are merged into every surviving snapshot.
module branch_checkpoint_stack #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned NUM_PR   = 64,
    parameter int unsigned N        = 2,
    localparam int unsigned TAG_W    = $clog2(DEPTH),
    localparam int unsigned PR_IDX_W = $clog2(NUM_PR),
    localparam int unsigned SC_W     = $clog2(N + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          dispatch_branch_valid,
    input  logic [NUM_PR-1:0]             dispatch_free_list,
    output logic [TAG_W-1:0]              dispatch_tag,
    output logic                          stack_full,
    output logic                          stack_empty,
    input  logic                          resolve_valid,
    input  logic [TAG_W-1:0]              resolve_tag,
    input  logic                          resolve_mispredict,
    input  logic [N-1:0][PR_IDX_W-1:0]    phys_reg_retiring,
    input  logic [SC_W-1:0]               num_retiring_valid,
    output logic [NUM_PR-1:0]             free_list_restore,
    output logic                          restore_flag,
    output logic [TAG_W:0]                num_live
);

    logic [NUM_PR-1:0] snapshot [DEPTH];
    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  resolved;
    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;

    logic              valid_resolve;
    logic              mispredict;
    logic              correct;
    logic              reclaim;
    logic              dispatch;
    logic [DEPTH-1:0]  squash;
    logic [NUM_PR-1:0] retire_mask;
    logic [TAG_W-1:0]  resolve_rel;
    logic [TAG_W:0]    younger_cnt;
    logic [TAG_W-1:0]  head_next;

    assign stack_full        = (count == (TAG_W+1)'(DEPTH));
    assign stack_empty       = (count == '0);
    assign num_live          = count;
    assign dispatch_tag      = tail;
    assign restore_flag      = mispredict;
    assign free_list_restore = mispredict ? snapshot[resolve_tag] : '0;

    // Resolve qualification and the set of entries squashed by a mispredict
    always_comb begin
        valid_resolve = resolve_valid & live[resolve_tag] & ~resolved[resolve_tag];
        mispredict    = valid_resolve & resolve_mispredict;
        correct       = valid_resolve & ~resolve_mispredict;
        resolve_rel   = resolve_tag - head;
        younger_cnt   = count - {1'b0, resolve_rel};
        squash        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mispredict && ({1'b0, TAG_W'(TAG_W'(i) - resolve_tag)} < younger_cnt)) begin
                squash[i] = 1'b1;
            end
        end
        reclaim   = live[head] & resolved[head] & ~squash[head];
        dispatch  = dispatch_branch_valid & ~stack_full & ~mispredict;
        head_next = head + TAG_W'(reclaim);
    end

    // One-hot merge of the valid retiring T_old registers
    always_comb begin
        retire_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (SC_W'(i) < num_retiring_valid) begin
                retire_mask[phys_reg_retiring[i]] = 1'b1;
            end
        end
    end

    // Head/tail/count bookkeeping; a mispredict rewinds tail to the resolved tag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_next;
            if (mispredict) begin
                tail  <= resolve_tag;
                count <= {1'b0, TAG_W'(resolve_tag - head_next)};
            end else begin
                if (dispatch) begin
                    tail <= tail + TAG_W'(1);
                end
                count <= count + (TAG_W+1)'(dispatch) - (TAG_W+1)'(reclaim);
            end
        end
    end

    // Per-entry live/resolved flags and snapshot contents
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live     <= '0;
            resolved <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash[i]) begin
                    live[i]     <= 1'b0;
                    resolved[i] <= 1'b0;
                end else if (reclaim && (head == TAG_W'(i))) begin
                    live[i]     <= 1'b0;
                    resolved[i] <= 1'b0;
                end else if (dispatch && (tail == TAG_W'(i))) begin
                    live[i]     <= 1'b1;
                    resolved[i] <= 1'b0;
                end else if (correct && (resolve_tag == TAG_W'(i))) begin
                    resolved[i] <= 1'b1;
                end

                if (dispatch && (tail == TAG_W'(i))) begin
                    snapshot[i] <= dispatch_free_list | retire_mask;
                end else if (live[i] && !squash[i]) begin
                    snapshot[i] <= snapshot[i] | retire_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_checkpoint_stack.sv
// Scoreboard bench for branch_checkpoint_stack: a queue-based reference model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_branch_checkpoint_stack;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NUM_PR = 64;
    localparam int unsigned N      = 2;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned SC_W   = 2;

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic                       dispatch_branch_valid = 1'b0;
    logic [NUM_PR-1:0]          dispatch_free_list = '0;
    logic [TAG_W-1:0]           dispatch_tag;
    logic                       stack_full;
    logic                       stack_empty;
    logic                       resolve_valid = 1'b0;
    logic [TAG_W-1:0]           resolve_tag = '0;
    logic                       resolve_mispredict = 1'b0;
    logic [N-1:0][IDX_W-1:0]    phys_reg_retiring = '0;
    logic [SC_W-1:0]            num_retiring_valid = '0;
    logic [NUM_PR-1:0]          free_list_restore;
    logic                       restore_flag;
    logic [TAG_W:0]             num_live;

    branch_checkpoint_stack #(.DEPTH(DEPTH), .NUM_PR(NUM_PR), .N(N)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .dispatch_branch_valid (dispatch_branch_valid),
        .dispatch_free_list    (dispatch_free_list),
        .dispatch_tag          (dispatch_tag),
        .stack_full            (stack_full),
        .stack_empty           (stack_empty),
        .resolve_valid         (resolve_valid),
        .resolve_tag           (resolve_tag),
        .resolve_mispredict    (resolve_mispredict),
        .phys_reg_retiring     (phys_reg_retiring),
        .num_retiring_valid    (num_retiring_valid),
        .free_list_restore     (free_list_restore),
        .restore_flag          (restore_flag),
        .num_live              (num_live)
    );

    always #5 clock = ~clock;

    // Model: in-flight branches in age order, oldest first
    typedef struct {
        int              tag;
        logic [NUM_PR-1:0] snap;
        bit              resolved;
    } ent_t;

    typedef struct {
        logic            restore;
        logic [NUM_PR-1:0] frl;
        int              tag;
        int              live;
        logic            full;
        logic            empty;
    } exp_t;

    ent_t mq[$];
    int   mhead = 0;
    exp_t expq[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dispatch_tag"}, 64'(dispatch_tag), 64'd0);
        check({tag, "_stack_full"}, 64'(stack_full), 64'd0);
        check({tag, "_stack_empty"}, 64'(stack_empty), 64'd1);
        check({tag, "_restore_flag"}, 64'(restore_flag), 64'd0);
        check({tag, "_free_list_restore"}, 64'(free_list_restore), 64'd0);
        check({tag, "_num_live"}, 64'(num_live), 64'd0);
    endtask

    task automatic drive_idle();
        dispatch_branch_valid = 1'b0;
        dispatch_free_list    = '0;
        resolve_valid         = 1'b0;
        resolve_tag           = '0;
        resolve_mispredict    = 1'b0;
        phys_reg_retiring     = '0;
        num_retiring_valid    = '0;
    endtask

    // Drive one cycle of stimulus, predict outputs, advance the model
    task automatic cycle(input logic dv, input logic [NUM_PR-1:0] dfl,
                         input logic rv, input int rtag, input logic rmis,
                         input int r0, input int r1, input int nrv);
        exp_t e;
        ent_t ne;
        int size, tl, pos;
        logic [NUM_PR-1:0] mask;
        bit vres, mis, recl;
        @(posedge clock);
        #1;
        dispatch_branch_valid = dv;
        dispatch_free_list    = dfl;
        resolve_valid         = rv;
        resolve_tag           = TAG_W'(rtag);
        resolve_mispredict    = rmis;
        phys_reg_retiring[0]  = IDX_W'(r0);
        phys_reg_retiring[1]  = IDX_W'(r1);
        num_retiring_valid    = SC_W'(nrv);

        size    = mq.size();
        tl      = (mhead + size) % DEPTH;
        e.restore = 1'b0;
        e.frl   = '0;
        e.tag   = tl;
        e.live  = size;
        e.full  = (size == DEPTH);
        e.empty = (size == 0);

        mask = '0;
        if (nrv > 0) mask[r0] = 1'b1;
        if (nrv > 1) mask[r1] = 1'b1;

        pos  = (rtag - mhead + DEPTH) % DEPTH;
        vres = 1'b0;
        if (rv && pos < size) begin
            if (!mq[pos].resolved) vres = 1'b1;
        end
        mis  = vres && rmis;
        recl = 1'b0;
        if (size > 0) recl = mq[0].resolved;

        if (mis) begin
            e.restore = 1'b1;
            e.frl     = mq[pos].snap;
        end
        expq.push_back(e);

        if (mis) begin
            while (mq.size() > pos) void'(mq.pop_back());
        end else if (vres) begin
            mq[pos].resolved = 1'b1;
        end
        foreach (mq[k]) mq[k].snap = mq[k].snap | mask;
        if (recl) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % DEPTH;
        end
        if (dv && size < DEPTH && !mis) begin
            ne.tag      = tl;
            ne.snap     = dfl | mask;
            ne.resolved = 1'b0;
            mq.push_back(ne);
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic disp(input logic [NUM_PR-1:0] fl);
        cycle(1'b1, fl, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic resolve(input int tag, input logic mis);
        cycle(1'b0, '0, 1'b1, tag, mis, 0, 0, 0);
    endtask

    // Synchronous-looking reset pulse used between directed sections
    task automatic do_reset();
        @(posedge clock);
        #1;
        drive_idle();
        reset = 1'b1;
        mq.delete();
        mhead = 0;
        #1;
        check_reset_outputs("reset_pulse");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every predicted cycle away from the active edge
    always @(negedge clock) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check("restore_flag", 64'(restore_flag), 64'(mon_e.restore));
            check("free_list_restore", 64'(free_list_restore), 64'(mon_e.frl));
            check("dispatch_tag", 64'(dispatch_tag), 64'(mon_e.tag));
            check("num_live", 64'(num_live), 64'(mon_e.live));
            check("stack_full", 64'(stack_full), 64'(mon_e.full));
            check("stack_empty", 64'(stack_empty), 64'(mon_e.empty));
        end
    end

    initial begin
        drive_idle();
        #2;
        check_reset_outputs("initial_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Three dispatches, mispredict the middle one with a dropped dispatch
        disp(64'h1);
        disp(64'hF0);
        disp(64'hABCD);
        idle_cycle();
        cycle(1'b1, 64'h7777, 1'b1, 1, 1'b1, 0, 0, 0);
        idle_cycle();
        resolve(0, 1'b1);
        idle_cycle();

        // Retired registers merge into a live snapshot before restore
        disp(64'h0);
        cycle(1'b0, '0, 1'b0, 0, 1'b0, 5, 9, 2);
        resolve(0, 1'b1);
        idle_cycle();

        // Fill, overflow attempt, correct resolve of head, wrap dispatch
        for (int i = 0; i < DEPTH; i++) disp({$urandom, $urandom});
        disp(64'hDEAD);
        resolve(0, 1'b0);
        idle_cycle();
        idle_cycle();
        disp(64'hBEEF);
        idle_cycle();
        resolve(1, 1'b1);
        idle_cycle();

        // Out-of-order correct resolves, then redundant resolves
        do_reset();
        disp(64'h11);
        disp(64'h22);
        disp(64'h33);
        resolve(2, 1'b0);
        resolve(1, 1'b0);
        resolve(0, 1'b0);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        resolve(1, 1'b1);
        disp(64'h44);
        disp(64'h55);
        resolve(4, 1'b0);
        resolve(4, 1'b1);
        idle_cycle();

        // Mid-cycle asynchronous reset with live entries
        do_reset();
        for (int i = 0; i < 4; i++) disp(64'(i + 1));
        idle_cycle();
        @(posedge clock);
        #1;
        drive_idle();
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        #1;
        reset = 1'b0;
        mq.delete();
        mhead = 0;
        disp(64'h99);
        idle_cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            cycle(($urandom_range(0, 9) < 6), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  ($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, NUM_PR - 1)), int'($urandom_range(0, NUM_PR - 1)),
                  int'($urandom_range(0, N)));
        end

        @(posedge clock);
        #1;
        drive_idle();
        repeat (2) @(negedge clock);
        #1;
        check("scoreboard_drain", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_checkpoint_stack.md
Name: branch_checkpoint_stack

Overview:
Circular checkpoint buffer holding free-list snapshots, one per in-flight branch. It sits between dispatch/execute and the free list and produces `free_list_restore` / `restore_flag` for it. Dispatch allocates a checkpoint per branch and receives a branch tag. Execute resolves tags: correct predictions release the checkpoint, and a mispredict restores the snapshot and squashes all younger checkpoints. Retiring T_old registers are merged into every live snapshot so restores never re-allocate freed-and-retired registers.

Parameters:
DEPTH, 8, number of checkpoint entries (power of 2); TAG_W = $clog2(DEPTH)
NUM_PR, `PHYS_REG_SZ_R10K, free-list bit-vector width
N, `N, superscalar width of retire port

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high
dispatch_branch_valid  input  1  allocate a checkpoint this cycle
dispatch_free_list  input  NUM_PR  free list as of the dispatching branch (post-allocation)
dispatch_tag  output  TAG_W  tag assigned to the dispatching branch (= tail)
stack_full  output  1  no free entry; dispatch must stall
stack_empty  output  1  no live entries
resolve_valid  input  1  a branch resolves this cycle
resolve_tag  input  TAG_W  tag being resolved
resolve_mispredict  input  1  1 = mispredict, 0 = correct
phys_reg_retiring  input  N x PHYS_REG_IDX  T_old registers being retired
num_retiring_valid  input  `NUM_SCALAR_BITS  count of valid retiring entries (lowest indices)
free_list_restore  output  NUM_PR  snapshot of the mispredicted branch
restore_flag  output  1  mispredict restore this cycle
num_live  output  TAG_W+1  occupied entries (head..tail)

Behaviour:
- State per entry: `snapshot[NUM_PR]`, `live`, `resolved`. Registers: `head`, `tail` (TAG_W, wrap mod DEPTH), `count` (TAG_W+1).
- Reset (async): head = tail = count = 0; all live/resolved = 0; snapshots = 0.
- Outputs at reset: dispatch_tag = 0, stack_full = 0, stack_empty = 1, restore_flag = 0, free_list_restore = 0, num_live = 0.
- Combinational outputs:
  - stack_full = (count == DEPTH); stack_empty = (count == 0); num_live = count; dispatch_tag = tail.
- Valid resolve:
  - Condition: resolve_valid & live[resolve_tag] & ~resolved[resolve_tag]. Invalid resolves are ignored entirely.
- Mispredict (valid resolve with resolve_mispredict = 1), same cycle, combinational:
  - restore_flag = 1.
  - free_list_restore = snapshot[resolve_tag] as currently stored. This excludes the current cycle's retirements; the free list ORs those itself.
- When no mispredict: restore_flag = 0 and free_list_restore = 0.
- Mispredict, next state:
  - Entries from resolve_tag up to tail-1 (wrapping) become not live and not resolved.
  - tail <= resolve_tag; count <= (resolve_tag - head) mod DEPTH. If resolve_tag == head, count <= 0.
  - A same-cycle dispatch is dropped, since it is younger.
- Correct resolve, next state: resolved[resolve_tag] <= 1; the entry stays occupied until reclaimed.
- Reclaim:
  - Each cycle, if live[head] & resolved[head] and the head is not squashed this cycle: live[head], resolved[head] <= 0; head <= head+1; count decrements.
  - At most one reclaim per cycle. A correctly resolved head is reclaimed the cycle after its resolve.
- Dispatch:
  - Takes effect if dispatch_branch_valid & ~stack_full & ~mispredict.
  - snapshot[tail] <= dispatch_free_list | retire_mask; live <= 1; resolved <= 0; tail <= tail+1; count increments.
  - stack_full is based on the registered count: a same-cycle reclaim does not unblock a dispatch.
- Simultaneous dispatch and reclaim: count is unchanged.
- Retire merge:
  - retire_mask = OR of onehot(phys_reg_retiring[i]) for i < num_retiring_valid.
  - Every live entry that is not squashed this cycle: snapshot <= snapshot | retire_mask.
  - A mispredicted or squashed entry is not updated.
- Wrap-around: head and tail wrap modulo DEPTH. Full vs empty is distinguished only by count.
- Asserting reset mid-operation discards all entries immediately, with no restore_flag.

Test Plan:
1. Reset, then dispatch 3 branches with free lists A, B, C -> tags 0, 1, 2; num_live = 3; stack_full = 0.
2. From (1), mispredict tag 1 -> same cycle restore_flag = 1, free_list_restore = B. Next cycle: tail = 1, num_live = 1, entries 1-2 not live; a same-cycle dispatch is dropped.
3. Dispatch tag 0 with snapshot 0, then retire regs {5, 9} (num_retiring_valid = 2), then mispredict tag 0 -> free_list_restore has bits 5 and 9 set; num_live = 0, stack_empty = 1.
4. Fill 8 entries -> stack_full = 1 and a 9th dispatch is ignored. Correctly resolve tag 0: num_live = 8 that cycle, 7 the next, head = 1. Then dispatch -> dispatch_tag = 0 (wrap).
5. Out-of-order correct resolves of tags 2 then 1 then 0 -> head advances 0 -> 1 -> 2 -> 3 on three consecutive cycles after tag 0 resolves. Resolving an already-resolved tag produces no state change and restore_flag = 0.
6. With 4 live entries, pulse reset between clock edges -> all outputs immediately return to their reset values; the next dispatch gets tag 0.
